// File: rtl/slot_reels_pkg.sv
// Shared definitions for the slot-machine reel generator: game states,
// LFSR constants, reel width and the reel/LFSR update helpers.
package slot_reels_pkg;

   localparam int unsigned REEL_W    = 5;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Feedback taps at bits 15, 13, 12 and 10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      SPIN1 = 2'd0,
      SPIN2 = 2'd1,
      SPIN3 = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Fibonacci LFSR step: shift left, feed XOR of tapped bits into bit 0
   function automatic logic [15:0] lfsr_next(input logic [15:0] x);
      return {x[14:0], ^(x & LFSR_TAPS)};
   endfunction

   // Advance a reel by s (1..4) modulo n, computed one bit wider than the reel
   function automatic logic [REEL_W-1:0] reel_advance(input logic [REEL_W-1:0] v,
                                                      input logic [2:0]        s,
                                                      input int unsigned       n);
      logic [REEL_W:0] sum;
      sum = {1'b0, v} + {{(REEL_W-2){1'b0}}, s};
      if (sum >= (REEL_W+1)'(n)) begin
         sum = sum - (REEL_W+1)'(n);
      end
      return sum[REEL_W-1:0];
   endfunction

endpackage

// File: rtl/slot_reels_key_edge.sv
// Key conditioner: two-flop synchronizer on an active-low raw key followed
// by a falling-edge detector producing a registered one-cycle press pulse.
module key_edge (
   input  logic clk_i,
   input  logic resetn_i,
   input  logic key_n_i,
   output logic press_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;
   logic press_q;

   // Synchronize the key, remember its previous level and flag high-to-low
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         meta_q  <= 1'b1;
         sync_q  <= 1'b1;
         prev_q  <= 1'b1;
         press_q <= 1'b0;
      end else begin
         meta_q  <= key_n_i;
         sync_q  <= meta_q;
         prev_q  <= sync_q;
         press_q <= prev_q & ~sync_q;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/slot_reels.sv
// Reel generator: three reels spin on a divided tick with LFSR-derived
// steps; ordered key presses freeze them, then report round done/jackpot.
module slot_reels
   import slot_reels_pkg::*;
#(
   parameter int unsigned NUM_SYMBOLS = 10,
   parameter int unsigned STEP_DIV    = 2_500_000,
   parameter int unsigned RANDOM_STEP = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              key_1,
   input  logic              key_2,
   input  logic              key_3,
   output logic [REEL_W-1:0] randomNum1,
   output logic [REEL_W-1:0] randomNum2,
   output logic [REEL_W-1:0] randomNum3,
   output logic [2:0]        reels_stopped,
   output logic              round_done,
   output logic              jackpot
);

   localparam int unsigned     CNT_W   = $clog2(STEP_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);

   logic [2:0]        press;
   logic [2:0]        freeze;
   logic [CNT_W-1:0]  cnt_q;
   logic              tick;
   logic [15:0]       lfsr_q;
   logic [2:0]        step   [3];
   logic [REEL_W-1:0] reel_q [3];
   logic [REEL_W-1:0] reel_d [3];
   state_e            state_q;
   logic [2:0]        stopped_q;
   logic              round_done_q;
   logic              jackpot_q;

   key_edge u_key1 (.clk_i(clk), .resetn_i(resetn), .key_n_i(key_1), .press_o(press[0]));
   key_edge u_key2 (.clk_i(clk), .resetn_i(resetn), .key_n_i(key_2), .press_o(press[1]));
   key_edge u_key3 (.clk_i(clk), .resetn_i(resetn), .key_n_i(key_3), .press_o(press[2]));

   // Tick divider: count 0..STEP_DIV-1 and wrap
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tick = (cnt_q == CNT_MAX);

   // Free-running LFSR, advances every clock
   always_ff @(posedge clk) begin
      if (!resetn) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_next(lfsr_q);
      end
   end

   // Only the press expected by the current state freezes a reel
   always_comb begin
      freeze = '0;
      case (state_q)
         SPIN1:   freeze[0] = press[0];
         SPIN2:   freeze[1] = press[1];
         SPIN3:   freeze[2] = press[2];
         default: freeze = '0;
      endcase
   end

   // Per-reel step and next value; a freezing reel keeps its pre-tick value
   always_comb begin
      for (int unsigned i = 0; i < 3; i++) begin
         if (RANDOM_STEP != 0) begin
            step[i] = 3'd1 + {1'b0, lfsr_q[2*i +: 2]};
         end else begin
            step[i] = 3'd1;
         end
         reel_d[i] = reel_q[i];
         if (tick && !stopped_q[i] && !freeze[i]) begin
            reel_d[i] = reel_advance(reel_q[i], step[i], NUM_SYMBOLS);
         end
      end
   end

   // Reel value registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < 3; i++) begin
            reel_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 3; i++) begin
            reel_q[i] <= reel_d[i];
         end
      end
   end

   // Round FSM with registered freeze bits, round-done pulse and jackpot
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= SPIN1;
         stopped_q    <= '0;
         round_done_q <= 1'b0;
         jackpot_q    <= 1'b0;
      end else begin
         round_done_q <= 1'b0;
         case (state_q)
            SPIN1: begin
               if (freeze[0]) begin
                  stopped_q[0] <= 1'b1;
                  state_q      <= SPIN2;
               end
            end
            SPIN2: begin
               if (freeze[1]) begin
                  stopped_q[1] <= 1'b1;
                  state_q      <= SPIN3;
               end
            end
            SPIN3: begin
               if (freeze[2]) begin
                  stopped_q[2] <= 1'b1;
                  state_q      <= DONE;
                  round_done_q <= 1'b1;
                  // Reel 3 holds its current value on this edge, so compare as-is
                  jackpot_q    <= (reel_q[0] == reel_q[1]) && (reel_q[1] == reel_q[2]);
               end
            end
            DONE: begin
               if (press[2]) begin
                  stopped_q <= '0;
                  state_q   <= SPIN1;
                  jackpot_q <= 1'b0;
               end
            end
            default: state_q <= SPIN1;
         endcase
      end
   end

   assign randomNum1    = reel_q[0];
   assign randomNum2    = reel_q[1];
   assign randomNum3    = reel_q[2];
   assign reels_stopped = stopped_q;
   assign round_done    = round_done_q;
   assign jackpot       = jackpot_q;

endmodule

// File: tb/tb_slot_reels.sv
// Directed bench for slot_reels: a deterministic instance for spin/stop
// sequences and a random-step instance checked against a reference model.
module tb_slot_reels;

   logic       clk = 1'b0;
   logic       resetn;
   logic       k1, k2, k3;
   logic [4:0] r1, r2, r3;
   logic [2:0] stopped;
   logic       rdone, jack;

   logic [4:0] q1, q2, q3;
   logic [2:0] q_stopped;
   logic       q_rdone, q_jack;

   int n_checks = 0;
   int n_fail   = 0;
   int rd_cnt   = 0;
   int rd_base;
   int rand_bad = 0;

   logic [15:0] m_lfsr;
   int          m_cnt, m_r1, m_r2, m_r3;

   always #5 clk = ~clk;

   slot_reels #(.NUM_SYMBOLS(10), .STEP_DIV(4), .RANDOM_STEP(0)) dut (
      .clk(clk), .resetn(resetn), .key_1(k1), .key_2(k2), .key_3(k3),
      .randomNum1(r1), .randomNum2(r2), .randomNum3(r3),
      .reels_stopped(stopped), .round_done(rdone), .jackpot(jack)
   );

   slot_reels #(.NUM_SYMBOLS(10), .STEP_DIV(2), .RANDOM_STEP(1)) u_rand (
      .clk(clk), .resetn(resetn), .key_1(1'b1), .key_2(1'b1), .key_3(1'b1),
      .randomNum1(q1), .randomNum2(q2), .randomNum3(q3),
      .reels_stopped(q_stopped), .round_done(q_rdone), .jackpot(q_jack)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reels(input string tag, input int a, input int b, input int c);
      check_eq({tag, "_r1"}, 32'(r1), a);
      check_eq({tag, "_r2"}, 32'(r2), b);
      check_eq({tag, "_r3"}, 32'(r3), c);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Pull the selected keys low for two cycles; the freeze lands on the last edge
   task automatic press(input logic [2:0] m);
      if (m[0]) k1 = 1'b0;
      if (m[1]) k2 = 1'b0;
      if (m[2]) k3 = 1'b0;
      cyc(2);
      k1 = 1'b1; k2 = 1'b1; k3 = 1'b1;
      cyc(2);
   endtask

   task automatic reset_dut();
      resetn = 1'b0;
      cyc(5);
      resetn = 1'b1;
   endtask

   function automatic int wrap10(input int v, input int s);
      int t;
      t = v + s;
      if (t >= 10) t = t - 10;
      return t;
   endfunction

   // Reference model of the random-step instance (STEP_DIV=2, 10 symbols)
   always @(posedge clk) begin
      if (!resetn) begin
         m_lfsr <= 16'hACE1;
         m_cnt  <= 0;
         m_r1   <= 0;
         m_r2   <= 0;
         m_r3   <= 0;
      end else begin
         if (m_cnt == 1) begin
            m_r1 <= wrap10(m_r1, 1 + int'(m_lfsr[1:0]));
            m_r2 <= wrap10(m_r2, 1 + int'(m_lfsr[3:2]));
            m_r3 <= wrap10(m_r3, 1 + int'(m_lfsr[5:4]));
         end
         m_cnt  <= (m_cnt == 1) ? 0 : m_cnt + 1;
         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      end
   end

   // Compare the random instance against the model every cycle out of reset
   always @(negedge clk) begin
      if (resetn) begin
         if (int'(q1) != m_r1 || int'(q2) != m_r2 || int'(q3) != m_r3) rand_bad++;
         if (q1 >= 5'd10 || q2 >= 5'd10 || q3 >= 5'd10) rand_bad++;
         if (u_rand.lfsr_q == 16'h0000 || u_rand.lfsr_q !== m_lfsr) rand_bad++;
      end
   end

   // Count round_done pulses
   always @(negedge clk) begin
      if (rdone === 1'b1) rd_cnt++;
   end

   initial begin
      resetn = 1'b0;
      k1 = 1'b1; k2 = 1'b1; k3 = 1'b1;
      cyc(5);
      check_reels("reset", 0, 0, 0);
      check_eq("reset_stopped", 32'(stopped), 0);
      check_eq("reset_jackpot", 32'(jack), 0);
      check_eq("reset_round_done", 32'(rdone), 0);
      check_eq("reset_lfsr", 32'(dut.lfsr_q), 32'hACE1);
      resetn = 1'b1;

      // Deterministic spin; random instance first tick uses LFSR 59C3 -> steps 4,1,1
      cyc(2);
      check_eq("rand_tick1_r1", 32'(q1), 4);
      check_eq("rand_tick1_r2", 32'(q2), 1);
      check_eq("rand_tick1_r3", 32'(q3), 1);
      cyc(2);
      check_reels("tick1", 1, 1, 1);
      check_eq("tick1_stopped", 32'(stopped), 0);
      cyc(32);
      check_reels("tick9", 9, 9, 9);
      cyc(4);
      check_reels("tick10_wrap", 0, 0, 0);

      // Ordered stop, each freeze coinciding with a tick
      reset_dut();
      cyc(12);
      check_reels("pre_stop", 3, 3, 3);
      press(3'b001);
      check_reels("stop1", 3, 4, 4);
      check_eq("stop1_stopped", 32'(stopped), 3'b001);
      cyc(36);
      press(3'b010);
      check_reels("stop2", 3, 3, 4);
      check_eq("stop2_stopped", 32'(stopped), 3'b011);
      cyc(36);
      rd_base = rd_cnt;
      press(3'b100);
      check_reels("stop3", 3, 3, 3);
      check_eq("stop3_stopped", 32'(stopped), 3'b111);
      check_eq("stop3_jackpot", 32'(jack), 1);
      cyc(8);
      check_reels("done_hold", 3, 3, 3);
      check_eq("done_jackpot", 32'(jack), 1);
      check_eq("done_round_done_low", 32'(rdone), 0);
      check_eq("jackpot_rd_pulses", 32'(rd_cnt - rd_base), 1);

      // Reset mid-round clears everything on the next edge
      resetn = 1'b0;
      cyc(1);
      check_reels("midreset", 0, 0, 0);
      check_eq("midreset_stopped", 32'(stopped), 0);
      check_eq("midreset_jackpot", 32'(jack), 0);
      check_eq("midreset_lfsr", 32'(dut.lfsr_q), 32'hACE1);
      cyc(4);
      resetn = 1'b1;

      // Mismatch round 3,4,5 then restart
      reset_dut();
      cyc(12);
      rd_base = rd_cnt;
      press(3'b001);
      press(3'b010);
      press(3'b100);
      check_reels("mismatch", 3, 4, 5);
      check_eq("mismatch_round_done", 32'(rdone), 1);
      check_eq("mismatch_jackpot", 32'(jack), 0);
      press(3'b100);
      check_eq("restart_stopped", 32'(stopped), 0);
      check_eq("restart_jackpot", 32'(jack), 0);
      check_reels("restart_hold", 3, 4, 5);
      cyc(4);
      check_reels("restart_resume", 4, 5, 6);
      check_eq("mismatch_rd_pulses", 32'(rd_cnt - rd_base), 1);

      // Out-of-order, simultaneous and held keys
      reset_dut();
      press(3'b010);
      check_eq("ooo_key2_stopped", 32'(stopped), 0);
      press(3'b100);
      check_eq("ooo_key3_stopped", 32'(stopped), 0);
      check_reels("ooo", 2, 2, 2);
      press(3'b111);
      check_reels("simul", 2, 3, 3);
      check_eq("simul_stopped", 32'(stopped), 3'b001);
      cyc(8);
      check_eq("simul_no_queue", 32'(stopped), 3'b001);
      check_reels("simul_spin", 2, 5, 5);
      press(3'b010);
      check_eq("held_pre_stopped", 32'(stopped), 3'b011);
      rd_base = rd_cnt;
      k3 = 1'b0;
      cyc(1000);
      k3 = 1'b1;
      cyc(8);
      check_eq("held_stopped", 32'(stopped), 3'b111);
      check_eq("held_rd_pulses", 32'(rd_cnt - rd_base), 1);
      check_reels("held", 2, 5, 6);
      check_eq("held_jackpot", 32'(jack), 0);

      // Long random-step run on the second instance
      cyc(60000);
      check_eq("rand_model_errors", 32'(rand_bad), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
